mem_bus_master: RTL

- Bus initiator for the shared tri-state sysbus used by the ROM/RAM slaves (MAR/MDR protocol).
- Converts a simple request/response interface into load_MAR / MDR_bus / load_MDR / CS / R_NW sequences.
- Supports single writes, plus single or burst reads with address auto-increment.
- Sits between the processor sequencer (or a test/DMA client) and the memory slaves on sysbus.

---
 rtl/mem_bus_master_if.sv | 28 ++
 rtl/mem_bus_master.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_bus_master_if.sv
// Request/response handshake between a client and mem_bus_master.
// The master modport is the bus-master side; slave is the requesting client.
interface mem_bus_master_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned OP_W   = 3
);
  localparam int unsigned ADDR_W = WORD_W - OP_W;

  logic              req;
  logic              rnw;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] len;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic [WORD_W-1:0] rdata;
  logic              rvalid;
  logic              done;

  modport master (
    input  req, rnw, addr, len, wdata,
    output ready, rdata, rvalid, done
  );

  modport slave (
    output req, rnw, addr, len, wdata,
    input  ready, rdata, rvalid, done
  );
endinterface

// File: rtl/mem_bus_master.sv
// sysbus initiator: turns single writes and single/burst reads into
// MAR/MDR strobe sequences, two cycles (ADDR, DATA) per beat.
module mem_bus_master #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned OP_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  mem_bus_master_if.master  host,
  output logic              load_MAR,
  output logic              load_MDR,
  output logic              MDR_bus,
  output logic              CS,
  output logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus
);
  localparam int unsigned ADDR_W = WORD_W - OP_W;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cur_addr, addr_n;
  logic [ADDR_W-1:0] count, count_n;
  logic [WORD_W-1:0] wdata_q, wdata_n;
  logic              rnw_q, rnw_n;
  logic              drive, drive_n;
  logic [WORD_W-1:0] bus_out, bus_n;
  logic [WORD_W-1:0] rdata_n;
  logic              rvalid_n, done_n, ready_n;
  logic              load_mar_n, load_mdr_n, mdr_bus_n, cs_n, r_nw_n;

  // Master only drives in ADDR and write-DATA, so never overlaps MDR_bus.
  assign sysbus = drive ? bus_out : {WORD_W{1'bz}};

  // State, transaction registers and all outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cur_addr    <= '0;
      count       <= '0;
      wdata_q     <= '0;
      rnw_q       <= 1'b1;
      drive       <= 1'b0;
      bus_out     <= '0;
      host.ready  <= 1'b1;
      host.rdata  <= '0;
      host.rvalid <= 1'b0;
      host.done   <= 1'b0;
      load_MAR    <= 1'b0;
      load_MDR    <= 1'b0;
      MDR_bus     <= 1'b0;
      CS          <= 1'b0;
      R_NW        <= 1'b1;
    end else begin
      state       <= state_n;
      cur_addr    <= addr_n;
      count       <= count_n;
      wdata_q     <= wdata_n;
      rnw_q       <= rnw_n;
      drive       <= drive_n;
      bus_out     <= bus_n;
      host.ready  <= ready_n;
      host.rdata  <= rdata_n;
      host.rvalid <= rvalid_n;
      host.done   <= done_n;
      load_MAR    <= load_mar_n;
      load_MDR    <= load_mdr_n;
      MDR_bus     <= mdr_bus_n;
      CS          <= cs_n;
      R_NW        <= r_nw_n;
    end
  end

  // Next state plus bus controls decoded from that next state, so the
  // registered strobes line up exactly with the state they belong to.
  always_comb begin
    state_n  = state;
    addr_n   = cur_addr;
    count_n  = count;
    wdata_n  = wdata_q;
    rnw_n    = rnw_q;
    rdata_n  = host.rdata;
    rvalid_n = 1'b0;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (host.req) begin
          addr_n  = host.addr;
          rnw_n   = host.rnw;
          wdata_n = host.wdata;
          count_n = host.rnw ? host.len : '0;
          state_n = ADDR;
        end
      end
      ADDR: state_n = DATA;
      DATA: begin
        if (rnw_q) begin
          rdata_n  = sysbus;
          rvalid_n = 1'b1;
        end
        if (count != '0) begin
          addr_n  = cur_addr + 1'b1;
          count_n = count - 1'b1;
          state_n = ADDR;
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n    = (state_n == IDLE);
    load_mar_n = (state_n == ADDR);
    cs_n       = (state_n == DATA);
    mdr_bus_n  = (state_n == DATA) && rnw_n;
    load_mdr_n = (state_n == DATA) && !rnw_n;
    r_nw_n     = !load_mdr_n;
    drive_n    = load_mar_n || load_mdr_n;
    bus_n      = load_mar_n ? {{OP_W{1'b0}}, addr_n} : wdata_n;
  end
endmodule
